// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game engine: state encodings, coordinate
// width and geometry helpers used to derive centre and clamp positions.
package pong_pkg;

   localparam int COORD_W = 10;

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_POINT = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   // Top-left position that centres an object of 'size' within 'span'.
   function automatic int centre_pos(input int span, input int size);
      return (span - size) / 2;
   endfunction

   // Largest top-left position that keeps an object of 'size' off the far wall.
   function automatic int hi_limit(input int span, input int wall, input int size);
      return span - wall - size;
   endfunction

endpackage

// File: rtl/pong_if.sv
// Signal bundle between the game engine and its surroundings (player inputs,
// tick generator, display controller, buzzer).
interface pong_if #(
   parameter int SCORE_W = 3
);
   import pong_pkg::*;

   // Protocol: there is no valid/ready handshake. Inputs are levels sampled on
   // every vga_clk edge; tick is a one-cycle strobe and a step happens on an
   // edge with tick=1 and pause=0. Outputs are registered, change only on a
   // step (or reset), and the hit/point outputs are one-cycle pulses.
   logic                tick;
   logic                pause;
   logic                start;
   logic                a_up;
   logic                a_down;
   logic                b_up;
   logic                b_down;
   logic [COORD_W-1:0]  x_ball;
   logic [COORD_W-1:0]  y_ball;
   logic [COORD_W-1:0]  y_paddle_a;
   logic [COORD_W-1:0]  y_paddle_b;
   logic [SCORE_W-1:0]  score_a;
   logic [SCORE_W-1:0]  score_b;
   logic [1:0]          state;
   logic                winner;
   logic                wall_hit;
   logic                paddle_hit;
   logic                point_a;
   logic                point_b;

   modport master (
      output tick, pause, start, a_up, a_down, b_up, b_down,
      input  x_ball, y_ball, y_paddle_a, y_paddle_b, score_a, score_b,
      input  state, winner, wall_hit, paddle_hit, point_a, point_b
   );

   modport slave (
      input  tick, pause, start, a_up, a_down, b_up, b_down,
      output x_ball, y_ball, y_paddle_a, y_paddle_b, score_a, score_b,
      output state, winner, wall_hit, paddle_hit, point_a, point_b
   );

endinterface

// File: rtl/pong_paddle.sv
// One paddle: moves up/down by PADDLE_VEL per enabled step, clamped between
// the top wall and the lowest position that keeps it off the bottom wall.
module pong_paddle
   import pong_pkg::*;
#(
   parameter int PADDLE_H   = 100,
   parameter int PADDLE_VEL = 2,
   parameter int V_RES      = 480,
   parameter int WALL       = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               up,
   input  logic               down,
   output logic [COORD_W-1:0] y
);

   localparam int W1 = COORD_W + 1;
   localparam logic [W1-1:0] Y_MIN = W1'(WALL);
   localparam logic [W1-1:0] Y_MAX = W1'(hi_limit(V_RES, WALL, PADDLE_H));
   localparam logic [W1-1:0] Y_RST = W1'(centre_pos(V_RES, PADDLE_H));
   localparam logic [W1-1:0] VEL   = W1'(PADDLE_VEL);

   logic [COORD_W-1:0] y_q, y_d;
   logic [W1-1:0]      y_ext;

   assign y_ext = {1'b0, y_q};
   assign y     = y_q;

   // Next position: one button moves, both or neither hold; clamp at the walls.
   always_comb begin
      y_d = y_q;
      if (en && up && !down) begin
         if (y_ext <= Y_MIN + VEL) y_d = Y_MIN[COORD_W-1:0];
         else                      y_d = y_q - VEL[COORD_W-1:0];
      end else if (en && down && !up) begin
         if (y_ext + VEL >= Y_MAX) y_d = Y_MAX[COORD_W-1:0];
         else                      y_d = y_q + VEL[COORD_W-1:0];
      end
   end

   // Position register, centred on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) y_q <= Y_RST[COORD_W-1:0];
      else     y_q <= y_d;
   end

endmodule

// File: rtl/pong_engine.sv
// Pong game engine: ball motion, wall/paddle bounces, scoring and the
// SERVE/PLAY/POINT/GAMEOVER sequence, advancing once per unpaused tick.
// Optional build macro PONG_SPEEDUP_EN: each paddle hit raises the x speed
// by one up to MAX_VEL; the speed drops back to BALL_VEL on every serve.
module pong_engine
   import pong_pkg::*;
#(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int WALL        = 5,
   parameter int BALL_SIZE   = 10,
   parameter int PADDLE_H    = 100,
   parameter int PADDLE_W    = 12,
   parameter int PADDLE_XA   = 20,
   parameter int PADDLE_XB   = 608,
   parameter int BALL_VEL    = 2,
   parameter int PADDLE_VEL  = 2,
   parameter int SCORE_W     = 3,
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 60,
   parameter int MAX_VEL     = 6
) (
   input logic   vga_clk,
   input logic   reset,
   pong_if.slave bus
);

   localparam int W1    = COORD_W + 1;
   localparam int CNT_W = $clog2(SERVE_TICKS + 1);
   localparam int VEL_W = $clog2(((MAX_VEL > BALL_VEL) ? MAX_VEL : BALL_VEL) + 1);

   localparam logic [COORD_W-1:0] X_CTR   = COORD_W'(centre_pos(H_RES, BALL_SIZE));
   localparam logic [COORD_W-1:0] Y_CTR   = COORD_W'(centre_pos(V_RES, BALL_SIZE));
   localparam logic [COORD_W-1:0] Y_TOP   = COORD_W'(WALL);
   localparam logic [COORD_W-1:0] Y_BOT   = COORD_W'(hi_limit(V_RES, WALL, BALL_SIZE));
   localparam logic [COORD_W-1:0] X_PAD_A = COORD_W'(PADDLE_XA + PADDLE_W);
   localparam logic [COORD_W-1:0] X_PAD_B = COORD_W'(PADDLE_XB - BALL_SIZE);
   localparam logic [COORD_W-1:0] VY      = COORD_W'(BALL_VEL);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_TICKS - 1);
   localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

   // 11-bit bounds so sums and differences never wrap.
   localparam logic [W1-1:0] L_TOP   = W1'(WALL);
   localparam logic [W1-1:0] L_BOT   = W1'(V_RES - WALL);
   localparam logic [W1-1:0] L_LEFT  = W1'(WALL);
   localparam logic [W1-1:0] L_RIGHT = W1'(H_RES - WALL);
   localparam logic [W1-1:0] L_BS    = W1'(BALL_SIZE);
   localparam logic [W1-1:0] L_PH    = W1'(PADDLE_H);
   localparam logic [W1-1:0] L_VY    = W1'(BALL_VEL);
   localparam logic [W1-1:0] L_PAD_A = W1'(PADDLE_XA + PADDLE_W);
   localparam logic [W1-1:0] L_PAD_B = W1'(PADDLE_XB);

   state_t              state_q, state_d;
   logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
   logic                dx_q, dx_d;          // 1 = moving right
   logic                dy_q, dy_d;          // 1 = moving down
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SCORE_W-1:0]  sa_q, sa_d, sb_q, sb_d;
   logic                winner_q, winner_d;
   logic                scorer_q, scorer_d;  // 1 = B won the pending point
   logic                wall_hit_q, wall_hit_d;
   logic                paddle_hit_q, paddle_hit_d;
   logic                point_a_q, point_a_d;
   logic                point_b_q, point_b_d;

   logic                step, pad_en;
   logic [VEL_W-1:0]    vel_x;
   logic [COORD_W-1:0]  vx10;
   logic [COORD_W-1:0]  pad_a_y, pad_b_y;
   logic [W1-1:0]       bx, by, pya, pyb, vx;
   logic                over_a, over_b;

   assign step   = bus.tick & ~bus.pause;
   assign pad_en = step && (state_q != ST_OVER);
   assign bx     = {1'b0, x_q};
   assign by     = {1'b0, y_q};
   assign pya    = {1'b0, pad_a_y};
   assign pyb    = {1'b0, pad_b_y};
   assign vx     = W1'(vel_x);
   assign vx10   = COORD_W'(vel_x);
   assign over_a = (by + L_BS > pya) && (by < pya + L_PH);
   assign over_b = (by + L_BS > pyb) && (by < pyb + L_PH);

   pong_paddle #(
      .PADDLE_H(PADDLE_H), .PADDLE_VEL(PADDLE_VEL), .V_RES(V_RES), .WALL(WALL)
   ) u_paddle_a (
      .clk(vga_clk), .rst(reset), .en(pad_en),
      .up(bus.a_up), .down(bus.a_down), .y(pad_a_y)
   );

   pong_paddle #(
      .PADDLE_H(PADDLE_H), .PADDLE_VEL(PADDLE_VEL), .V_RES(V_RES), .WALL(WALL)
   ) u_paddle_b (
      .clk(vga_clk), .rst(reset), .en(pad_en),
      .up(bus.b_up), .down(bus.b_down), .y(pad_b_y)
   );

   // Game FSM next state: ball physics in PLAY, scoring in POINT, serve delay.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      dx_d         = dx_q;
      dy_d         = dy_q;
      cnt_d        = cnt_q;
      sa_d         = sa_q;
      sb_d         = sb_q;
      winner_d     = winner_q;
      scorer_d     = scorer_q;
      wall_hit_d   = 1'b0;
      paddle_hit_d = 1'b0;
      point_a_d    = 1'b0;
      point_b_d    = 1'b0;
      if (step) begin
         case (state_q)
            ST_SERVE: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_PLAY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_PLAY: begin
               // Vertical axis.
               if (!dy_q && by <= L_TOP + L_VY) begin
                  y_d        = Y_TOP;
                  dy_d       = 1'b1;
                  wall_hit_d = 1'b1;
               end else if (dy_q && by + L_BS + L_VY >= L_BOT) begin
                  y_d        = Y_BOT;
                  dy_d       = 1'b0;
                  wall_hit_d = 1'b1;
               end else begin
                  y_d = dy_q ? (y_q + VY) : (y_q - VY);
               end
               // Horizontal axis: paddle face, then goal line, else move.
               if (!dx_q) begin
                  if (bx >= L_PAD_A && bx - vx <= L_PAD_A && over_a) begin
                     x_d          = X_PAD_A;
                     dx_d         = 1'b1;
                     paddle_hit_d = 1'b1;
                  end else if (bx <= L_LEFT + vx) begin
                     state_d  = ST_POINT;
                     scorer_d = 1'b1;
                  end else begin
                     x_d = x_q - vx10;
                  end
               end else begin
                  if (bx + L_BS <= L_PAD_B && bx + L_BS + vx >= L_PAD_B && over_b) begin
                     x_d          = X_PAD_B;
                     dx_d         = 1'b0;
                     paddle_hit_d = 1'b1;
                  end else if (bx + L_BS + vx >= L_RIGHT) begin
                     state_d  = ST_POINT;
                     scorer_d = 1'b0;
                  end else begin
                     x_d = x_q + vx10;
                  end
               end
            end
            ST_POINT: begin
               if (scorer_q) begin
                  sb_d      = sb_q + SCORE_W'(1);
                  point_b_d = 1'b1;
               end else begin
                  sa_d      = sa_q + SCORE_W'(1);
                  point_a_d = 1'b1;
               end
               if ((scorer_q ? sb_d : sa_d) == WIN) begin
                  state_d  = ST_OVER;
                  winner_d = scorer_q;
               end else begin
                  // Serve travels toward the player who just lost the point.
                  state_d = ST_SERVE;
                  x_d     = X_CTR;
                  y_d     = Y_CTR;
                  dx_d    = ~scorer_q;
               end
            end
            ST_OVER: begin
               if (bus.start) begin
                  sa_d    = '0;
                  sb_d    = '0;
                  state_d = ST_SERVE;
                  x_d     = X_CTR;
                  y_d     = Y_CTR;
               end
            end
         endcase
      end
   end

   // Game state registers; everything returns to the serve position on reset.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_SERVE;
         x_q          <= X_CTR;
         y_q          <= Y_CTR;
         dx_q         <= 1'b1;
         dy_q         <= 1'b1;
         cnt_q        <= '0;
         sa_q         <= '0;
         sb_q         <= '0;
         winner_q     <= 1'b0;
         scorer_q     <= 1'b0;
         wall_hit_q   <= 1'b0;
         paddle_hit_q <= 1'b0;
         point_a_q    <= 1'b0;
         point_b_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         cnt_q        <= cnt_d;
         sa_q         <= sa_d;
         sb_q         <= sb_d;
         winner_q     <= winner_d;
         scorer_q     <= scorer_d;
         wall_hit_q   <= wall_hit_d;
         paddle_hit_q <= paddle_hit_d;
         point_a_q    <= point_a_d;
         point_b_q    <= point_b_d;
      end
   end

`ifdef PONG_SPEEDUP_EN
   logic             enter_serve;
   logic [VEL_W-1:0] vel_q, vel_d;

   assign enter_serve = (state_d == ST_SERVE) && (state_q != ST_SERVE);
   assign vel_x       = vel_q;

   // X speed: back to base on a new serve, otherwise bump on each paddle hit.
   always_comb begin
      vel_d = vel_q;
      if (enter_serve)
         vel_d = VEL_W'(BALL_VEL);
      else if (paddle_hit_d && vel_q < VEL_W'(MAX_VEL))
         vel_d = vel_q + VEL_W'(1);
   end

   // X speed register.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) vel_q <= VEL_W'(BALL_VEL);
      else       vel_q <= vel_d;
   end
`else
   assign vel_x = VEL_W'(BALL_VEL);
`endif

   assign bus.x_ball     = x_q;
   assign bus.y_ball     = y_q;
   assign bus.y_paddle_a = pad_a_y;
   assign bus.y_paddle_b = pad_b_y;
   assign bus.score_a    = sa_q;
   assign bus.score_b    = sb_q;
   assign bus.state      = state_q;
   assign bus.winner     = winner_q;
   assign bus.wall_hit   = wall_hit_q;
   assign bus.paddle_hit = paddle_hit_q;
   assign bus.point_a    = point_a_q;
   assign bus.point_b    = point_b_q;

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: directed scenarios plus randomized play compared
// cycle by cycle against a behavioural game model. WIN_SCORE is lowered to 2
// so game-over is reached quickly.
module tb_pong_engine;

   localparam int H_RES = 640, V_RES = 480, WALL = 5, BALL_SIZE = 10;
   localparam int PADDLE_H = 100, PADDLE_W = 12, PADDLE_XA = 20, PADDLE_XB = 608;
   localparam int BALL_VEL = 2, PADDLE_VEL = 2, SERVE_TICKS = 60, MAX_VEL = 6;
   localparam int WIN = 2;
   localparam int P_MAX = V_RES - WALL - PADDLE_H;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pong_if #(.SCORE_W(3)) bus ();

   pong_engine #(.WIN_SCORE(WIN)) dut (
      .vga_clk(clk),
      .reset(rst),
      .bus(bus)
   );

   int checks = 0;
   int passed = 0;

   // ---------------- behavioural model ----------------
   int m_bx, m_by, m_pa, m_pb, m_sa, m_sb, m_st, m_win;
   int m_dx, m_dy, m_vx, m_cnt, m_scorer;
   bit m_wall, m_phit, m_pta, m_ptb;
   int n_wall, n_phit, n_pt;

   task automatic model_reset();
      m_bx = 315; m_by = 235; m_pa = 190; m_pb = 190;
      m_sa = 0; m_sb = 0; m_st = 0; m_win = 0;
      m_dx = 1; m_dy = 1; m_vx = BALL_VEL; m_cnt = 0; m_scorer = 0;
      m_wall = 0; m_phit = 0; m_pta = 0; m_ptb = 0;
   endtask

   function automatic int mv_paddle(int p, logic up, logic dn);
      if (up && !dn) return (p - PADDLE_VEL < WALL) ? WALL : p - PADDLE_VEL;
      if (dn && !up) return (p + PADDLE_VEL > P_MAX) ? P_MAX : p + PADDLE_VEL;
      return p;
   endfunction

   function automatic bit overlap(int by, int py);
      return (by + BALL_SIZE > py) && (by < py + PADDLE_H);
   endfunction

   task automatic centre_serve();
      m_st = 0; m_bx = 315; m_by = 235; m_vx = BALL_VEL;
   endtask

   task automatic model_step();
      int ox, oy, opa, opb;
      m_wall = 0; m_phit = 0; m_pta = 0; m_ptb = 0;
      if (!(bus.tick && !bus.pause)) return;
      ox = m_bx; oy = m_by; opa = m_pa; opb = m_pb;
      if (m_st != 3) begin
         m_pa = mv_paddle(m_pa, bus.a_up, bus.a_down);
         m_pb = mv_paddle(m_pb, bus.b_up, bus.b_down);
      end
      case (m_st)
         0: begin
            if (m_cnt == SERVE_TICKS - 1) begin m_cnt = 0; m_st = 1; end
            else m_cnt++;
         end
         1: begin
            if (m_dy < 0 && oy <= WALL + BALL_VEL) begin
               m_by = WALL; m_dy = 1; m_wall = 1;
            end else if (m_dy > 0 && oy + BALL_SIZE + BALL_VEL >= V_RES - WALL) begin
               m_by = V_RES - WALL - BALL_SIZE; m_dy = -1; m_wall = 1;
            end else m_by = oy + m_dy * BALL_VEL;
            if (m_dx < 0) begin
               if (ox >= PADDLE_XA + PADDLE_W && ox - m_vx <= PADDLE_XA + PADDLE_W && overlap(oy, opa)) begin
                  m_bx = PADDLE_XA + PADDLE_W; m_dx = 1; m_phit = 1;
               end else if (ox <= WALL + m_vx) begin
                  m_st = 2; m_scorer = 1;
               end else m_bx = ox - m_vx;
            end else begin
               if (ox + BALL_SIZE <= PADDLE_XB && ox + BALL_SIZE + m_vx >= PADDLE_XB && overlap(oy, opb)) begin
                  m_bx = PADDLE_XB - BALL_SIZE; m_dx = -1; m_phit = 1;
               end else if (ox + BALL_SIZE + m_vx >= H_RES - WALL) begin
                  m_st = 2; m_scorer = 0;
               end else m_bx = ox + m_vx;
            end
`ifdef PONG_SPEEDUP_EN
            if (m_phit && m_vx < MAX_VEL) m_vx++;
`endif
         end
         2: begin
            if (m_scorer == 1) begin m_sb++; m_ptb = 1; end
            else begin m_sa++; m_pta = 1; end
            if ((m_scorer == 1 ? m_sb : m_sa) == WIN) begin
               m_st = 3; m_win = m_scorer;
            end else begin
               centre_serve();
               m_dx = (m_scorer == 1) ? -1 : 1;
            end
         end
         default: begin
            if (bus.start) begin m_sa = 0; m_sb = 0; centre_serve(); end
         end
      endcase
      n_wall += m_wall; n_phit += m_phit; n_pt += (m_pta | m_ptb);
   endtask

   function automatic logic [52:0] exp_vec();
      return {10'(m_bx), 10'(m_by), 10'(m_pa), 10'(m_pb), 3'(m_sa), 3'(m_sb),
              2'(m_st), 1'(m_win), m_wall, m_phit, m_pta, m_ptb};
   endfunction

   function automatic logic [52:0] got_vec();
      return {bus.x_ball, bus.y_ball, bus.y_paddle_a, bus.y_paddle_b, bus.score_a,
              bus.score_b, bus.state, bus.winner, bus.wall_hit, bus.paddle_hit,
              bus.point_a, bus.point_b};
   endfunction

   // Paddle steering toward the model ball: {up, down}.
   function automatic logic [1:0] track(int py, int by);
      int tgt = by + BALL_SIZE / 2 - PADDLE_H / 2;
      if (py < tgt - 1) return 2'b01;
      if (py > tgt + 1) return 2'b10;
      return 2'b00;
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input bit t, input bit p, input bit s,
                        input bit au, input bit ad, input bit bu, input bit bd);
      bus.tick = t; bus.pause = p; bus.start = s;
      bus.a_up = au; bus.a_down = ad; bus.b_up = bu; bus.b_down = bd;
   endtask

   task automatic clk_step();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) clk_step();
      checks++;
      if ({bus.x_ball, bus.y_ball} !== {10'd315, 10'd235})
         $display("FAIL reset_ball got %0d/%0d want 315/235", bus.x_ball, bus.y_ball);
      else passed++;
      checks++;
      if ({bus.y_paddle_a, bus.y_paddle_b} !== {10'd190, 10'd190})
         $display("FAIL reset_paddles got %0d/%0d want 190/190", bus.y_paddle_a, bus.y_paddle_b);
      else passed++;
      checks++;
      if ({bus.score_a, bus.score_b, bus.state, bus.winner} !== 9'd0)
         $display("FAIL reset_score_state got sa=%0d sb=%0d st=%0d w=%0d want 0", bus.score_a, bus.score_b, bus.state, bus.winner);
      else passed++;
      checks++;
      if ({bus.wall_hit, bus.paddle_hit, bus.point_a, bus.point_b} !== 4'b0)
         $display("FAIL reset_pulses got %b want 0000", {bus.wall_hit, bus.paddle_hit, bus.point_a, bus.point_b});
      else passed++;
      rst = 1'b0;
      clk_step();
      checks++;
      if (got_vec() !== exp_vec()) $display("FAIL post_reset_idle got %h want %h", got_vec(), exp_vec());
      else passed++;
   endtask

   task automatic test_paddles();
      int ea, eb;
      // Both buttons on both paddles: no movement.
      for (int k = 1; k <= 10; k++) begin
         drive(1, 0, 0, 1, 1, 1, 1);
         clk_step();
         checks++;
         if ({bus.y_paddle_a, bus.y_paddle_b} !== {10'd190, 10'd190})
            $display("FAIL paddle_both step %0d got %0d/%0d want 190/190", k, bus.y_paddle_a, bus.y_paddle_b);
         else passed++;
      end
      // A up, B down for 100 steps: both clamp from step 93.
      for (int k = 1; k <= 100; k++) begin
         drive(1, 0, 0, 1, 0, 0, 1);
         clk_step();
         ea = (190 - 2 * k < 5) ? 5 : 190 - 2 * k;
         eb = (190 + 2 * k > 375) ? 375 : 190 + 2 * k;
         checks++;
         if ({bus.y_paddle_a, bus.y_paddle_b} !== {10'(ea), 10'(eb)})
            $display("FAIL paddle_move step %0d got %0d/%0d want %0d/%0d", k, bus.y_paddle_a, bus.y_paddle_b, ea, eb);
         else passed++;
      end
      checks++;
      if (got_vec() !== exp_vec()) $display("FAIL paddle_end_state got %h want %h", got_vec(), exp_vec());
      else passed++;
   endtask

   task automatic test_random_play(input int n);
      int mode = 0;
      logic [1:0] ta, tb2;
      n_wall = 0; n_phit = 0; n_pt = 0;
      for (int i = 0; i < n; i++) begin
         if (i % 200 == 0) mode = $urandom_range(0, 2);
         ta  = track(m_pa, m_by);
         tb2 = track(m_pb, m_by);
         if (mode == 0) begin
            ta  = 2'($urandom_range(0, 3));
            tb2 = 2'($urandom_range(0, 3));
         end else if (mode == 2) begin
            tb2 = 2'($urandom_range(0, 3));
         end
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
               ta[1], ta[0], tb2[1], tb2[0]);
         clk_step();
         checks++;
         if (got_vec() !== exp_vec())
            $display("FAIL random_play cycle %0d got %h want %h", i, got_vec(), exp_vec());
         else passed++;
      end
      $display("random play: %0d wall hits, %0d paddle hits, %0d points", n_wall, n_phit, n_pt);
   endtask

   task automatic test_async_reset();
      int guard = 0;
      logic [1:0] ta, tb2;
      while (bus.state !== 2'd1 && guard < 2000) begin
         ta = track(m_pa, m_by); tb2 = track(m_pb, m_by);
         drive(1, 0, 1, ta[1], ta[0], tb2[1], tb2[0]);
         clk_step();
         guard++;
      end
      checks++;
      if (bus.state !== 2'd1) $display("FAIL reach_play_timeout got state %0d want 1", bus.state);
      else passed++;
      repeat (5) begin
         drive(1, 0, 0, 1, 0, 0, 1);
         clk_step();
      end
      // Assert reset between edges and look before the next edge.
      #3 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({bus.x_ball, bus.y_ball, bus.y_paddle_a, bus.y_paddle_b} !== {10'd315, 10'd235, 10'd190, 10'd190})
         $display("FAIL async_reset_coords got %0d/%0d/%0d/%0d want 315/235/190/190",
                  bus.x_ball, bus.y_ball, bus.y_paddle_a, bus.y_paddle_b);
      else passed++;
      checks++;
      if ({bus.score_a, bus.score_b, bus.state} !== 8'd0)
         $display("FAIL async_reset_state got sa=%0d sb=%0d st=%0d want 0", bus.score_a, bus.score_b, bus.state);
      else passed++;
      drive(0, 0, 0, 0, 0, 0, 0);
      clk_step();
      rst = 1'b0;
   endtask

   // A parked at the top, B tracks: wait for A to miss.
   task automatic play_until_point_b(input string tag, output bit seen);
      logic [1:0] tb2;
      seen = 0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         tb2 = track(m_pb, m_by);
         drive(1, 0, 0, 1, 0, tb2[1], tb2[0]);
         clk_step();
         if (bus.point_b === 1'b1) seen = 1;
      end
   endtask

   task automatic test_point_serve();
      bit seen;
      int steps;
      play_until_point_b("first", seen);
      checks++;
      if (!seen) $display("FAIL point_b_timeout got no point_b want point_b");
      else passed++;
      checks++;
      if ({bus.score_b, bus.state, bus.x_ball, bus.y_ball} !== {3'd1, 2'd0, 10'd315, 10'd235})
         $display("FAIL after_point got sb=%0d st=%0d ball=%0d/%0d want 1/0/315/235",
                  bus.score_b, bus.state, bus.x_ball, bus.y_ball);
      else passed++;
      checks++;
      if (got_vec() !== exp_vec()) $display("FAIL after_point_model got %h want %h", got_vec(), exp_vec());
      else passed++;
      // Count serve steps, with a paused stretch that must not advance anything.
      steps = 0;
      while (bus.state === 2'd0 && steps < 200) begin
         if (steps == 20) begin
            repeat (15) begin
               drive(1, 1, 0, 1, 0, 0, 0);
               clk_step();
            end
            checks++;
            if ({bus.state, bus.x_ball, bus.point_b} !== {2'd0, 10'd315, 1'b0})
               $display("FAIL pause_freeze got st=%0d x=%0d pb=%0d want 0/315/0", bus.state, bus.x_ball, bus.point_b);
            else passed++;
         end
         drive(1, 0, 0, 1, 0, 0, 0);
         clk_step();
         steps++;
      end
      checks++;
      if (steps !== SERVE_TICKS) $display("FAIL serve_length got %0d steps want %0d", steps, SERVE_TICKS);
      else passed++;
      drive(1, 0, 0, 1, 0, 0, 0);
      clk_step();
      checks++;
      if (bus.x_ball !== 10'd313) $display("FAIL serve_toward_loser got x=%0d want 313", bus.x_ball);
      else passed++;
   endtask

   task automatic test_gameover();
      bit seen;
      logic [39:0] held;
      play_until_point_b("second", seen);
      if (seen) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         clk_step();
      end
      checks++;
      if ({bus.state, bus.winner, bus.score_b} !== {2'd3, 1'b1, 3'(WIN)})
         $display("FAIL gameover got st=%0d w=%0d sb=%0d want 3/1/%0d", bus.state, bus.winner, bus.score_b, WIN);
      else passed++;
      held = {bus.x_ball, bus.y_ball, bus.y_paddle_a, bus.y_paddle_b};
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, 0, k[0], 1'b0, 1'b0, ~k[0]);
         clk_step();
         checks++;
         if ({bus.x_ball, bus.y_ball, bus.y_paddle_a, bus.y_paddle_b, bus.state} !== {held, 2'd3})
            $display("FAIL gameover_hold step %0d got %h want %h", k,
                     {bus.x_ball, bus.y_ball, bus.y_paddle_a, bus.y_paddle_b, bus.state}, {held, 2'd3});
         else passed++;
      end
      drive(1, 1, 1, 0, 0, 0, 0);
      clk_step();
      checks++;
      if (bus.state !== 2'd3) $display("FAIL start_while_paused got st=%0d want 3", bus.state);
      else passed++;
      drive(1, 0, 1, 0, 0, 0, 0);
      clk_step();
      checks++;
      if ({bus.state, bus.score_a, bus.score_b, bus.x_ball, bus.y_ball} !== {2'd0, 3'd0, 3'd0, 10'd315, 10'd235})
         $display("FAIL restart got st=%0d sa=%0d sb=%0d ball=%0d/%0d want 0/0/0/315/235",
                  bus.state, bus.score_a, bus.score_b, bus.x_ball, bus.y_ball);
      else passed++;
      checks++;
      if (got_vec() !== exp_vec()) $display("FAIL restart_model got %h want %h", got_vec(), exp_vec());
      else passed++;
   endtask

   initial begin
      test_reset();
      test_paddles();
      test_random_play(6000);
      test_async_reset();
      test_point_serve();
      test_gameover();
      test_random_play(1500);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
